// File: rtl/square_wave_meter.sv
// Square-wave period meter: synchronizes an asynchronous square wave, measures the
// rising-edge to rising-edge period in clk cycles and reports period, floor(log2(period)),
// a power-of-two flag, a lock flag and a no-edge timeout.
// Optional duty-cycle measurement (high_o, sym_o) is built when SQUARE_METER_DUTY_EN is defined.
module square_wave_meter #(
  parameter int unsigned SIZE     = 24,
  parameter int unsigned PERIOD_W = SIZE + 2,
  parameter int unsigned EXP_W    = $clog2(PERIOD_W),
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                sig_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic [EXP_W-1:0]    exp_o,
  output logic                pow2_o,
  output logic                valid_o,
  output logic                locked_o,
  output logic                timeout_o,
  output logic [PERIOD_W-1:0] high_o,
  output logic                sym_o
);

  localparam int unsigned          MATCH_W   = $clog2(LOCK_CNT + 1);
  localparam logic [PERIOD_W-1:0]  CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0]   MATCH_TOP = MATCH_W'(LOCK_CNT - 1);

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  // Index of the most significant set bit (0 for a zero input).
  function automatic logic [EXP_W-1:0] msb_idx(input logic [PERIOD_W-1:0] v);
    logic [EXP_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < PERIOD_W; i++) begin
      if (v[i]) idx = EXP_W'(i);
    end
    return idx;
  endfunction

  // sync_q[0] is the metastability flop, sync_q[1] the synchronized level, sync_q[2] its delay.
  logic [2:0]          sync_q, sync_d;
  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [EXP_W-1:0]    exp_q, exp_d;
  logic                pow2_q, pow2_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic [MATCH_W-1:0]  match_q, match_d;

  logic rise, arm, measure, expire;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign arm     = (state_q == StIdle) & rise;
  assign measure = (state_q == StMeasure) & rise;
  // A rise on the final count wins over the timeout.
  assign expire  = (state_q == StMeasure) & ~rise & (cnt_q == CNT_MAX);

  // Synchronizer shift chain next state.
  always_comb begin
    sync_d = {sync_q[1:0], sig_i};
  end

  // FSM next state, period counter, measurement and lock tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    exp_d     = exp_q;
    pow2_d    = pow2_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
    match_d   = match_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d   = StMeasure;
          cnt_d     = PERIOD_W'(1);
          timeout_d = 1'b0;
        end
      end
      StMeasure: begin
        if (measure) begin
          cnt_d    = PERIOD_W'(1);
          valid_d  = 1'b1;
          period_d = cnt_q;
          exp_d    = msb_idx(cnt_q);
          pow2_d   = ((cnt_q & (cnt_q - PERIOD_W'(1))) == '0);
          if (cnt_q == period_q) begin
            match_d  = (match_q == MATCH_TOP) ? match_q : match_q + MATCH_W'(1);
            locked_d = (match_d == MATCH_TOP);
          end else begin
            match_d  = '0;
            locked_d = 1'b0;
          end
        end else if (expire) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = '0;
          period_d  = '0;
          exp_d     = '0;
          pow2_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync_q    <= '0;
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      exp_q     <= '0;
      pow2_q    <= 1'b0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
      match_q   <= '0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      exp_q     <= exp_d;
      pow2_q    <= pow2_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
      match_q   <= match_d;
    end
  end

  assign period_o  = period_q;
  assign exp_o     = exp_q;
  assign pow2_o    = pow2_q;
  assign valid_o   = valid_q;
  assign locked_o  = locked_q;
  assign timeout_o = timeout_q;

`ifdef SQUARE_METER_DUTY_EN
  logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
  logic [PERIOD_W-1:0] high_q, high_d;
  logic                sym_q, sym_d;

  // High-time counter; the rise cycle itself is the first high cycle of the new period.
  always_comb begin
    hcnt_d = hcnt_q;
    high_d = high_q;
    sym_d  = sym_q;
    if (arm || measure) begin
      hcnt_d = PERIOD_W'(1);
    end else if (state_q == StIdle) begin
      hcnt_d = '0;
    end else if (sync_q[1]) begin
      hcnt_d = hcnt_q + PERIOD_W'(1);
    end
    if (measure) begin
      high_d = hcnt_q;
      sym_d  = ({hcnt_q, 1'b0} == {1'b0, cnt_q});
    end else if (expire) begin
      high_d = '0;
      sym_d  = 1'b0;
    end
  end

  // Duty registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      hcnt_q <= '0;
      high_q <= '0;
      sym_q  <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
      sym_q  <= sym_d;
    end
  end

  assign high_o = high_q;
  assign sym_o  = sym_q;
`else
  assign high_o = '0;
  assign sym_o  = 1'b0;
`endif

endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: waveform stimulus with a reference model tracking rise
// times; expected reports are queued at stimulus time and popped by a monitor on valid_o.
module tb_square_wave_meter;

  localparam int unsigned SIZE     = 6;
  localparam int unsigned PERIOD_W = SIZE + 2;
  localparam int unsigned EXP_W    = $clog2(PERIOD_W);
  localparam int unsigned LOCK_CNT = 4;
  localparam int          MAXP     = (1 << PERIOD_W) - 1;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic                sig_i = 1'b0;
  logic [PERIOD_W-1:0] period_o;
  logic [EXP_W-1:0]    exp_o;
  logic                pow2_o, valid_o, locked_o, timeout_o, sym_o;
  logic [PERIOD_W-1:0] high_o;

  square_wave_meter #(
    .SIZE(SIZE), .PERIOD_W(PERIOD_W), .EXP_W(EXP_W), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst_i(rst_i), .sig_i(sig_i), .period_o(period_o), .exp_o(exp_o),
    .pow2_o(pow2_o), .valid_o(valid_o), .locked_o(locked_o), .timeout_o(timeout_o),
    .high_o(high_o), .sym_o(sym_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int e;
    int pw;
    int lk;
    int hi;
    int sym;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model state
  int cyc = 0;
  bit prev_lvl = 1'b0;
  bit armed = 1'b0;
  int last_rise = 0;
  int hi_cnt = 0;
  int run_p = 0;
  int run_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  function automatic int flog2(input int p);
    int e = 0;
    while ((2 << e) <= p) e++;
    return e;
  endfunction

  // Drive one clk cycle of level lvl and advance the model.
  task automatic step(input bit lvl);
    @(negedge clk);
    sig_i = lvl;
    cyc++;
    if (lvl && !prev_lvl) begin
      if (armed && (cyc - last_rise) <= MAXP) begin
        exp_t x;
        x.p = cyc - last_rise;
        if (x.p == run_p) run_len++;
        else begin
          run_p   = x.p;
          run_len = 1;
        end
        x.e   = flog2(x.p);
        x.pw  = ($countones(x.p) == 1);
        x.lk  = (run_len >= LOCK_CNT);
        x.hi  = hi_cnt;
        x.sym = (2 * hi_cnt == x.p);
        exp_q.push_back(x);
      end else begin
        run_p   = 0;
        run_len = 0;
      end
      armed     = 1'b1;
      last_rise = cyc;
      hi_cnt    = 1;
    end else if (lvl) begin
      hi_cnt++;
    end
    prev_lvl = lvl;
  endtask

  task automatic drive_wave(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < hi; j++) step(1'b1);
      for (int j = 0; j < lo; j++) step(1'b0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " period"}, period_o, 0);
    check({tag, " exp"}, exp_o, 0);
    check({tag, " pow2"}, pow2_o, 0);
    check({tag, " valid"}, valid_o, 0);
    check({tag, " locked"}, locked_o, 0);
    check({tag, " timeout"}, timeout_o, 0);
    check({tag, " high"}, high_o, 0);
    check({tag, " sym"}, sym_o, 0);
  endtask

  // Let pending reports drain, then reset with sig_i low.
  task automatic do_reset(input int n);
    for (int j = 0; j < 4; j++) step(1'b0);
    @(negedge clk);
    rst_i = 1'b1;
    sig_i = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    repeat (n - 1) @(negedge clk);
    rst_i    = 1'b0;
    prev_lvl = 1'b0;
    armed    = 1'b0;
    run_p    = 0;
    run_len  = 0;
  endtask

  // Monitor: every valid_o pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got period %0d expected no report", period_o);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("period", period_o, x.p);
        check("exp", exp_o, x.e);
        check("pow2", pow2_o, x.pw);
        check("locked", locked_o, x.lk);
`ifdef SQUARE_METER_DUTY_EN
        check("high", high_o, x.hi);
        check("sym", sym_o, x.sym);
`else
        check("high_tied", high_o, 0);
        check("sym_tied", sym_o, 0);
`endif
      end
    end
  end

  initial begin
    // Reset held 5 cycles with sig_i low
    repeat (5) @(negedge clk);
    check_all_zero("reset_hold");
    rst_i = 1'b0;

    // Period 8, 4 high / 4 low: locks on the fourth report
    drive_wave(4, 4, 6);
    check("locked_p8", locked_o, 1);

    // Toggling every cycle
    drive_wave(1, 1, 10);

    // Period 8 then switch to 16
    drive_wave(4, 4, 5);
    drive_wave(8, 8, 5);
    check("relocked_p16", locked_o, 1);

    // Period 12, 3 high / 9 low
    drive_wave(3, 9, 5);

    // Reset mid-period while locked, then re-arm
    drive_wave(4, 4, 6);
    step(1'b1);
    step(1'b1);
    do_reset(2);
    drive_wave(4, 4, 4);

    // Timeout after a single rise held low
    step(1'b1);
    repeat (250) step(1'b0);
    check("timeout_early", timeout_o, 0);
    repeat (50) step(1'b0);
    check("timeout_set", timeout_o, 1);
    check("timeout_period", period_o, 0);
    check("timeout_locked", locked_o, 0);
    check("timeout_pow2", pow2_o, 0);
    drive_wave(4, 4, 5);
    check("timeout_cleared", timeout_o, 0);

    // Longest measurable period, then one cycle too long
    drive_wave(1, 254, 2);
    drive_wave(1, 255, 2);

    // Randomized segments
    for (int s = 0; s < 30; s++) begin
      int p, hi, n;
      p  = $urandom_range(40, 2);
      hi = $urandom_range(p - 1, 1);
      n  = $urandom_range(6, 1);
      drive_wave(hi, p - hi, n);
    end

    repeat (10) step(1'b0);
    check("pending_reports", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
